// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port arbiter and access sequencer for the data memory.
//               Port 0 is the core load/store path and port 1 is the
//               DMA/debug loader. Each access is latched in IDLE, checked
//               for size/alignment legality, driven to memory for exactly
//               one ACCESS cycle, and acknowledged for one DONE cycle with
//               registered read data.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   p0_* / p1_*          requester inputs (req/we/addr/wdata/size) and
//                        completion outputs (ack/err)
//   rdata                load result, valid while either ack is high
//   busy                 high whenever the sequencer is not idle
//   mem_access/we/addr/
//   wdata/size           data-memory command (registered)
//   mem_rdata            combinational read data from the memory
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    // Only 32 is supported; the size/alignment checks assume a 4-byte word.
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [2:0]        p0_size,
    output logic              p0_ack,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [2:0]        p1_size,
    output logic              p1_ack,
    output logic              p1_err,

    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic              mem_access,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    // ------------------------------------------------------------------
    // funct3 size codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_SIZE_B  = 3'd0;
    localparam logic [2:0] c_SIZE_H  = 3'd1;
    localparam logic [2:0] c_SIZE_W  = 3'd2;
    localparam logic [2:0] c_SIZE_BU = 3'd4;
    localparam logic [2:0] c_SIZE_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_ptr;        // round-robin priority: 0 = port 0
    logic              r_owner;      // port that owns the in-flight access
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_size;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic              r_mem_access;
    logic              r_mem_we;

    // ------------------------------------------------------------------
    // Request selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic              w_any_req;
    logic              w_grant1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [2:0]        w_sel_size;
    logic              w_sel_err;

    // Illegal size codes, or a half/word whose address is not naturally
    // aligned. Byte accesses are legal at any address.
    function automatic logic f_illegal(input logic [2:0] size,
                                       input logic [1:0] lsb);
        logic bad;
        case (size)
            c_SIZE_B, c_SIZE_BU: bad = 1'b0;
            c_SIZE_H, c_SIZE_HU: bad = lsb[0];
            c_SIZE_W:            bad = (lsb != 2'b00);
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign w_any_req = p0_req | p1_req;

    // Port 1 wins when it is the only requester, or when both request and
    // the pointer favours it. Otherwise port 0 is selected.
    assign w_grant1 = p1_req & (~p0_req | r_ptr);

    assign w_sel_we    = w_grant1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_grant1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_grant1 ? p1_wdata : p0_wdata;
    assign w_sel_size  = w_grant1 ? p1_size  : p0_size;
    assign w_sel_err   = f_illegal(w_sel_size, w_sel_addr[1:0]);

    // ------------------------------------------------------------------
    // Sequencer
    // mem_access/mem_we are computed on the IDLE->ACCESS edge so they are
    // high for exactly the ACCESS cycle, straight from flops. mem_addr,
    // mem_wdata and mem_size are the latched command and simply hold
    // between accesses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= 3'd0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_mem_access <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant1;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_size       <= w_sel_size;
                        r_err        <= w_sel_err;
                        // An erroneous command never reaches the memory.
                        r_mem_access <= ~w_sel_err;
                        r_mem_we     <= w_sel_we & ~w_sel_err;
                        r_state      <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    r_mem_access <= 1'b0;
                    r_mem_we     <= 1'b0;
                    // Stores and rejected accesses return zero so rdata
                    // never shows stale or undriven memory data.
                    r_rdata      <= (~r_we & ~r_err) ? mem_rdata : '0;
                    r_ack0       <= ~r_owner;
                    r_ack1       <= r_owner;
                    r_err0       <= ~r_owner & r_err;
                    r_err1       <= r_owner & r_err;
                    r_state      <= S_DONE;
                end

                S_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    // Hand priority to the other port so a waiting
                    // requester is served after at most one foreign access.
                    r_ptr   <= ~r_owner;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_mem_access <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_err0       <= 1'b0;
                    r_err1       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all flops or a decode of the state register
    // ------------------------------------------------------------------
    assign p0_ack     = r_ack0;
    assign p0_err     = r_err0;
    assign p1_ack     = r_ack1;
    assign p1_err     = r_err1;
    assign rdata      = r_rdata;
    assign busy       = (r_state != S_IDLE);
    assign mem_access = r_mem_access;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_size   = r_size;

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the core's data memory. It shares the single data-memory port between the core load/store path (port 0) and the DMA/debug loader (port 1). Each access is latched, checked for alignment and size legality, driven to memory for exactly one cycle, and answered with a one-cycle acknowledge carrying registered read data. It sits between the requesters and the data memory and is the only block that drives the memory's access, write-enable, address, write-data and size inputs.

## Interface
- Parameters:
- ADDR_W, 32, address width passed through to memory
- DATA_W, 32, data width; fixed at 32, other values unsupported
- Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- p0_req / p1_req  in  1  request valid; held with fields stable until the matching ack
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_wdata / p1_wdata  in  32  store data, low-aligned
- p0_size / p1_size  in  3  funct3 code: 0 = byte, 1 = half, 2 = word, 4 = unsigned byte, 5 = unsigned half
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  valid with ack; 1 = misaligned or illegal size, no memory access made
- rdata  out  32  load result, valid while an ack is high; shared by both ports
- busy  out  1  high in every state except IDLE
- mem_access  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_size  out  3  memory size code
- mem_rdata  in  32  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select the owner, latch we/addr/wdata/size, compute the error flag, and go to ACCESS.
- Owner selection: if only one port requests, that port wins. If both request, the round-robin pointer decides. The pointer resets to 0 (port 0).
- Error flag: set when size is 3, 6 or 7; or size is 1/5 and addr[0] = 1; or size is 2 and addr[1:0] != 0.
- ACCESS:
  - No error: mem_access = 1, and mem_* carry the latched command for this one cycle.
  - Error: mem_access = 0.
  - Capture into rdata at the end of the cycle: mem_rdata when the access is a load without error; 0 for stores and errors.
  - Go to DONE.
- DONE:
  - Owner's ack = 1 and err = latched flag; the other port's ack = 0.
  - Pointer is set to the non-owner.
  - Go to IDLE.
- Signal behaviour outside ACCESS: mem_access = 0 and mem_we = 0 in every other state. mem_addr, mem_wdata and mem_size hold the last latched values.
- A write never occurs while mem_access = 0.
- rdata holds its value until the next ACCESS completes.
- Requester rule: a port whose req is still high in the cycle after its ack is treated as issuing a new request.
- Starvation bound: a waiting port is served after at most one access by the other port.

## Timing
- Sequence for a request sampled at edge E0 (IDLE):
  - ACCESS runs in the cycle after E0.
  - Read data is captured at E1.
  - ack is high in the cycle after E1.
  - State is IDLE again after E2.
- Fixed latency: req seen at E0 → ack in cycle E1–E2. Back-to-back throughput is one access per 3 cycles.
- Outputs are registered or decoded from registered state only. No combinational path from any p*_req to mem_* or ack.
- Asynchronous reset (any state, including mid-ACCESS) clears immediately: state = IDLE, pointer = 0, p0_ack = p1_ack = 0, p0_err = p1_err = 0, rdata = 0, busy = 0, mem_access = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_size = 0.
- An in-flight access is dropped and never acknowledged; the requester re-issues it after reset.
- Requests arriving while busy = 1 are not sampled until the FSM is back in IDLE.

## Test plan
- Single word store then load:
  - p0 stores 0xDEADBEEF at 0x10 (size 2): mem_access and mem_we are high for exactly 1 cycle, then p0_ack is high 1 cycle with err = 0.
  - p0 then loads 0x10: rdata = 0xDEADBEEF with p0_ack, 2 cycles after req is sampled.
- Simultaneous requests from reset:
  - p0 and p1 both request continuously: grants alternate p0, p1, p0, p1.
  - Each ack is spaced 3 cycles apart, and no ack is ever high on both ports.
- Misaligned and illegal accesses:
  - Word at 0x102, half at 0x101, and size 3 at 0x100: each gives err = 1 with ack, rdata = 0, and mem_access stays 0 throughout.
- Sub-word pass-through:
  - Byte load (size 0) and unsigned-half load (size 5) at 0x20: mem_size equals the request code during ACCESS.
  - rdata equals mem_rdata captured at the end of ACCESS.
- Reset mid-access:
  - Assert rst during ACCESS of a p1 store: mem_access and mem_we drop the same cycle, all outputs return to reset values, and no p1_ack is ever issued.
  - The first grant after reset goes to p0 when both ports request.
